// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues imem requests at the current PC, buffers returned
// words with their PCs in a small ring, and hands them to decode over valid/ready.
module fetch_unit #(
    parameter int width_p = 32,
    parameter int depth_p = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [width_p-1:0] pc_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic               imem_req_valid_o,
    output logic [width_p-1:0] imem_req_addr_o,
    input  logic               imem_req_ready_i,
    input  logic               imem_rsp_valid_i,
    input  logic [31:0]        imem_rsp_data_i,
    output logic               instr_valid_o,
    output logic [31:0]        instr_o,
    output logic [width_p-1:0] instr_pc_o,
    input  logic               instr_ready_i
);
    localparam int idx_w = $clog2(depth_p);
    localparam int ptr_w = idx_w + 1;
    localparam int cnt_w = ptr_w + 1;

    logic [ptr_w-1:0]   r_alloc_ptr;
    logic [ptr_w-1:0]   r_fill_ptr;
    logic [ptr_w-1:0]   r_rd_ptr;
    logic [ptr_w-1:0]   r_discard_cnt;

    logic [ptr_w-1:0]   w_occupancy;
    logic [ptr_w-1:0]   w_inflight;
    logic [cnt_w-1:0]   w_committed;
    logic               w_credit;
    logic               w_accept;
    logic               w_rsp_fill;
    logic               w_pop;
    logic [idx_w-1:0]   w_alloc_idx;
    logic [idx_w-1:0]   w_fill_idx;
    logic [idx_w-1:0]   w_rd_idx;

    logic [width_p-1:0] w_slot_pc     [depth_p];
    logic [31:0]        w_slot_instr  [depth_p];
    logic               w_slot_filled [depth_p];

    assign w_occupancy = r_alloc_ptr - r_rd_ptr;
    assign w_inflight  = r_alloc_ptr - r_fill_ptr;
    // Fetches still owed to the discard backlog hold credit just like buffered ones.
    assign w_committed = cnt_w'(w_occupancy) + cnt_w'(r_discard_cnt);
    assign w_credit    = (w_committed < cnt_w'(depth_p));

    assign w_alloc_idx = r_alloc_ptr[idx_w-1:0];
    assign w_fill_idx  = r_fill_ptr[idx_w-1:0];
    assign w_rd_idx    = r_rd_ptr[idx_w-1:0];

    assign imem_req_valid_o = w_credit & ~flush_i & ~rst_i;
    assign imem_req_addr_o  = pc_i;
    assign w_accept         = imem_req_valid_o & imem_req_ready_i;
    assign stall_o          = ~w_accept;

    assign w_rsp_fill    = imem_rsp_valid_i & (r_discard_cnt == '0);
    assign instr_valid_o = (w_occupancy != '0) & w_slot_filled[w_rd_idx];
    assign instr_o       = w_slot_instr[w_rd_idx];
    assign instr_pc_o    = w_slot_pc[w_rd_idx];
    assign w_pop         = instr_valid_o & instr_ready_i & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_alloc_ptr   <= '0;
            r_fill_ptr    <= '0;
            r_rd_ptr      <= '0;
            r_discard_cnt <= '0;
        end else if (flush_i) begin
            // Every fetch still in flight must be dropped when it returns,
            // including one that is returning right now.
            r_alloc_ptr   <= '0;
            r_fill_ptr    <= '0;
            r_rd_ptr      <= '0;
            r_discard_cnt <= r_discard_cnt + w_inflight - ptr_w'(imem_rsp_valid_i);
        end else begin
            if (w_accept) begin
                r_alloc_ptr <= r_alloc_ptr + 1'b1;
            end
            if (imem_rsp_valid_i) begin
                if (r_discard_cnt != '0) begin
                    r_discard_cnt <= r_discard_cnt - 1'b1;
                end else begin
                    r_fill_ptr <= r_fill_ptr + 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < depth_p; gi++) begin : g_slot
            logic [width_p-1:0] r_pc;
            logic [31:0]        r_instr;
            logic               r_filled;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_pc     <= '0;
                    r_instr  <= '0;
                    r_filled <= 1'b0;
                end else if (!flush_i) begin
                    // Alloc and fill never target the same slot in one cycle.
                    if (w_accept && (w_alloc_idx == idx_w'(gi))) begin
                        r_pc     <= pc_i;
                        r_filled <= 1'b0;
                    end
                    if (w_rsp_fill && (w_fill_idx == idx_w'(gi))) begin
                        r_instr  <= imem_rsp_data_i;
                        r_filled <= 1'b1;
                    end
                end
            end

            assign w_slot_pc[gi]     = r_pc;
            assign w_slot_instr[gi]  = r_instr;
            assign w_slot_filled[gi] = r_filled;
        end
    endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order imem model with programmable latency,
// a PC model that follows stall_o, and a scoreboard of expected (pc, instr) pairs.
module tb_fetch_unit;
    localparam int W = 32;
    localparam int D = 2;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [W-1:0] pc_i = '0;
    logic         flush_i = 1'b0;
    logic         stall_o;
    logic         imem_req_valid_o;
    logic [W-1:0] imem_req_addr_o;
    logic         imem_req_ready_i = 1'b1;
    logic         imem_rsp_valid_i = 1'b0;
    logic [31:0]  imem_rsp_data_i = '0;
    logic         instr_valid_o;
    logic [31:0]  instr_o;
    logic [W-1:0] instr_pc_o;
    logic         instr_ready_i = 1'b1;

    always #5 clk_i = ~clk_i;

    fetch_unit #(.width_p(W), .depth_p(D)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .pc_i             (pc_i),
        .flush_i          (flush_i),
        .stall_o          (stall_o),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_ready_i    (instr_ready_i)
    );

    typedef struct { logic [31:0] pc; logic filled; } exp_t;
    typedef struct { logic [31:0] data; int due; logic stale; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    int          cyc = 0;
    int          lat = 1;
    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    int          first_acc = -1;
    int          first_pop = -1;
    logic [31:0] first_pop_pc = '0;
    logic [31:0] last_pop_pc = '0;
    logic [31:0] pc_m = '0;
    logic [31:0] flush_tgt = '0;
    logic [31:0] held_pc;

    function automatic logic [31:0] imem_word(logic [31:0] a);
        return ~a ^ 32'h5A5A_0000 ^ {a[15:0], 16'h0000};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: sample and check at the falling edge, update models after the rising edge.
    task automatic step();
        logic        acc, pop, rsp, fl, exp_credit;
        logic [31:0] s_pc, s_addr;
        int          stale_cnt;
        pend_t       p;
        @(negedge clk_i);
        fl     = flush_i;
        rsp    = imem_rsp_valid_i;
        s_pc   = pc_i;
        s_addr = imem_req_addr_o;
        acc    = imem_req_valid_o & imem_req_ready_i;
        pop    = instr_valid_o & instr_ready_i & ~fl;
        stale_cnt = 0;
        foreach (pend_q[i]) if (pend_q[i].stale) stale_cnt++;
        exp_credit = ((exp_q.size() + stale_cnt) < D);
        assert (!(rsp && pend_q.size() == 0)) else $error("FAIL rsp_legal: response with nothing outstanding");
        chk("req_valid", 32'(imem_req_valid_o), 32'(exp_credit && !fl));
        chk("stall", 32'(stall_o), 32'(!(exp_credit && !fl && imem_req_ready_i)));
        chk("req_addr", s_addr, s_pc);
        chk("instr_valid", 32'(instr_valid_o), 32'(exp_q.size() > 0 && exp_q[0].filled));
        if (pop) begin
            if (exp_q.size() > 0) begin
                chk("pop_pc", instr_pc_o, exp_q[0].pc);
                chk("pop_instr", instr_o, imem_word(exp_q[0].pc));
            end else begin
                chk("pop_unexpected", 32'(pop), 32'd0);
            end
            if (first_pop < 0) begin
                first_pop    = cyc;
                first_pop_pc = instr_pc_o;
            end
            last_pop_pc = instr_pc_o;
            pops++;
        end
        @(posedge clk_i);
        #1;
        if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (rsp && pend_q.size() > 0) begin
            p = pend_q.pop_front();
            if (!p.stale && !fl) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (!exp_q[i].filled) begin
                        exp_q[i].filled = 1'b1;
                        break;
                    end
                end
            end
        end
        if (fl) begin
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            exp_q.delete();
            pc_m = flush_tgt;
        end else if (acc) begin
            exp_q.push_back('{s_pc, 1'b0});
            pend_q.push_back('{imem_word(s_addr), cyc + lat, 1'b0});
            pc_m = pc_m + 32'd4;
            if (first_acc < 0) first_acc = cyc;
        end
        cyc++;
        pc_i    = pc_m;
        flush_i = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = pend_q[0].data;
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Stop issuing and let every outstanding fetch return and be consumed.
    task automatic drain();
        int budget;
        imem_req_ready_i = 1'b0;
        instr_ready_i    = 1'b1;
        budget = 0;
        while ((exp_q.size() > 0 || pend_q.size() > 0) && budget < 50) begin
            step();
            budget++;
        end
        chk("drain_done", 32'(exp_q.size() + pend_q.size()), 32'd0);
    endtask

    task automatic expect_next_pop(string tag, logic [31:0] pc_exp);
        int start, budget;
        start  = pops;
        budget = 0;
        while (pops == start && budget < 40) begin
            step();
            budget++;
        end
        if (pops == start) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=no pop in 40 cycles expected=pop of pc %h", tag, pc_exp);
        end else begin
            chk(tag, last_pop_pc, pc_exp);
        end
    endtask

    initial begin
        #1;
        chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd1);
        chk("rst_instr_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_instr_pc", instr_pc_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Streaming with 1-cycle imem latency and decode always ready.
        run(12);
        chk("first_latency", 32'(first_pop - first_acc), 32'(lat + 1));
        chk("first_pc", first_pop_pc, 32'd0);

        // Decode stalled: buffer fills, then fetch stops until decode drains it.
        drain();
        instr_ready_i    = 1'b0;
        imem_req_ready_i = 1'b1;
        run(4);
        #1;
        chk("full_stall", 32'(stall_o), 32'd1);
        chk("full_req_valid", 32'(imem_req_valid_o), 32'd0);
        instr_ready_i = 1'b1;
        run(6);

        // Flush with two fetches in flight: both responses are discarded.
        drain();
        lat = 3;
        imem_req_ready_i = 1'b1;
        run(2);
        chk("two_inflight", 32'(pend_q.size()), 32'd2);
        flush_tgt = 32'h100;
        flush_i   = 1'b1;
        step();
        expect_next_pop("flush_pc", 32'h100);
        run(4);

        // Flush in the cycle a response arrives, one more fetch still in flight.
        drain();
        lat = 2;
        imem_req_ready_i = 1'b1;
        run(2);
        chk("rsp_at_flush", 32'(imem_rsp_valid_i), 32'd1);
        flush_tgt = 32'h200;
        flush_i   = 1'b1;
        step();
        expect_next_pop("flush_rsp_pc", 32'h200);
        run(4);

        // imem not ready: request held at the same address, PC stalled.
        drain();
        lat = 1;
        held_pc = pc_m;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk("hold_addr", imem_req_addr_o, held_pc);
            chk("hold_stall", 32'(stall_o), 32'd1);
        end
        imem_req_ready_i = 1'b1;
        run(4);

        // Asynchronous reset mid-cycle with the buffer full.
        instr_ready_i = 1'b0;
        run(6);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("arst_stall", 32'(stall_o), 32'd1);
        chk("arst_instr_valid", 32'(instr_valid_o), 32'd0);
        chk("arst_instr", instr_o, 32'd0);
        chk("arst_instr_pc", instr_pc_o, 32'd0);
        exp_q.delete();
        pend_q.delete();
        pc_m             = '0;
        pc_i             = '0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        instr_ready_i = 1'b1;
        expect_next_pop("post_reset_pc", 32'd0);
        run(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
